// File: rtl/pulser_pkg.sv
// Shared constants for the multi-channel push-button pulser:
// FSM state encoding and counter-width helpers.
package pulser_pkg;

  // Per-channel FSM states (2-bit encoding kept for legacy compatibility)
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ARMED     = 2'd1;
  localparam logic [1:0] ST_REPEATING = 2'd2;

  // Bits needed to hold values 0..max_count (at least one bit)
  function automatic int cnt_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

  // Larger of two integers, used to size the shared repeat counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_pulser_channel.sv
// One push-button channel: synchroniser, debounce filter, press/repeat FSM
// and repeat counter. Produces a registered one-cycle pulse per debounced
// press and per auto-repeat deadline, plus the debounced level.
module pb_pulser_channel
  import pulser_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_in,
  input  logic repeat_en,
  output logic pulse_out,
  output logic pb_level
);

  localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0]  DB_ZERO      = '0;
  localparam logic [DB_W-1:0]  DB_ONE       = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ZERO     = '0;
  localparam logic [RPT_W-1:0] RPT_ONE      = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_MAX      = '1;
  localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  logic [DB_W-1:0]        db_cnt;
  logic                   accept;
  logic                   rise;
  logic                   fall;
  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [RPT_W-1:0]       rpt_cnt;
  logic [RPT_W-1:0]       rpt_cnt_nxt;
  logic [RPT_W-1:0]       rpt_cnt_inc;
  logic                   pulse_nxt;

  assign sync = sync_ff[SYNC_STAGES-1];

  // Debounce decision for this edge: the synchronised level has disagreed
  // with the accepted level long enough, so it is accepted now.
  assign accept = (sync != pb_level) && (db_cnt == DB_LAST);
  assign rise   = accept && !pb_level;
  assign fall   = accept && pb_level;

  // Saturating increment so a long hold can never wrap the repeat counter
  assign rpt_cnt_inc = (rpt_cnt == RPT_MAX) ? rpt_cnt : rpt_cnt + RPT_ONE;

  // Shift the raw asynchronous button level through the synchroniser chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], pb_in};
    end
  end

  // Debounce counter: count disagreeing cycles, toggle the level when full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt   <= DB_ZERO;
      pb_level <= 1'b0;
    end else if (sync == pb_level) begin
      db_cnt <= DB_ZERO;
    end else if (db_cnt == DB_LAST) begin
      db_cnt   <= DB_ZERO;
      pb_level <= ~pb_level;
    end else begin
      db_cnt <= db_cnt + DB_ONE;
    end
  end

  // Next-state logic; an accepted release overrides any repeat deadline
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    pulse_nxt   = 1'b0;
    if (fall) begin
      state_nxt   = ST_IDLE;
      rpt_cnt_nxt = RPT_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            pulse_nxt   = 1'b1;
            state_nxt   = ST_ARMED;
            rpt_cnt_nxt = RPT_ONE;
          end
        end
        ST_ARMED: begin
          if (!repeat_en) begin
            rpt_cnt_nxt = RPT_ONE;
          end else if (rpt_cnt >= RPT_DELAY_V) begin
            pulse_nxt   = 1'b1;
            state_nxt   = ST_REPEATING;
            rpt_cnt_nxt = RPT_ONE;
          end else begin
            rpt_cnt_nxt = rpt_cnt_inc;
          end
        end
        ST_REPEATING: begin
          if (!repeat_en) begin
            state_nxt   = ST_ARMED;
            rpt_cnt_nxt = RPT_ONE;
          end else if (rpt_cnt >= RPT_PERIOD_V) begin
            pulse_nxt   = 1'b1;
            rpt_cnt_nxt = RPT_ONE;
          end else begin
            rpt_cnt_nxt = rpt_cnt_inc;
          end
        end
        default: begin
          state_nxt   = ST_IDLE;
          rpt_cnt_nxt = RPT_ZERO;
        end
      endcase
    end
  end

  // Register FSM state, repeat counter and the outgoing pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rpt_cnt   <= RPT_ZERO;
      pulse_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      rpt_cnt   <= rpt_cnt_nxt;
      pulse_out <= pulse_nxt;
    end
  end

endmodule

// File: rtl/multi_one_pulser.sv
// Multi-channel push-button front end: N_CH independent pulser channels,
// each turning a bouncing asynchronous button into clean one-cycle pulses.
module multi_one_pulser #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] pb_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] pulse_out,
  output logic [N_CH-1:0] pb_level
);

  // One fully independent channel per button; no shared logic
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pb_pulser_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .pb_in    (pb_in[g]),
      .repeat_en(repeat_en[g]),
      .pulse_out(pulse_out[g]),
      .pb_level (pb_level[g])
    );
  end

endmodule
